tl_ul_arb2: RTL

TL_UL_ARB2 -- requirements
Module: tl_ul_arb2

---
 rtl/tl_ul_arb2.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/tl_ul_arb2.sv
// Two-master TL-UL arbiter: round-robin A-channel arbitration into a one-entry
// output slice, per-master outstanding limits, and combinational D-channel routing.
module tl_ul_arb2 #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        m0_a_valid,
    output logic        m0_a_ready,
    input  logic [78:0] m0_a_bits,
    input  logic        m1_a_valid,
    output logic        m1_a_ready,
    input  logic [78:0] m1_a_bits,
    output logic        s_a_valid,
    input  logic        s_a_ready,
    output logic [79:0] s_a_bits,
    input  logic        s_d_valid,
    output logic        s_d_ready,
    input  logic [45:0] s_d_bits,
    output logic        m0_d_valid,
    input  logic        m0_d_ready,
    output logic [44:0] m0_d_bits,
    output logic        m1_d_valid,
    input  logic        m1_d_ready,
    output logic [44:0] m1_d_bits,
    output logic        idle
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    logic        slice_valid_r;
    logic [79:0] slice_bits_r;
    logic        rr_ptr_r;
    logic [2:0]  cnt0_r;
    logic [2:0]  cnt1_r;

    logic        elig0_s, elig1_s, win1_s, loadable_s;
    logic        a_hs0_s, a_hs1_s, d_hs0_s, d_hs1_s, d_sel_s;
    logic [79:0] win_bits_s;
    logic [2:0]  cnt0_nxt_s, cnt1_nxt_s;

    // A response with nothing outstanding holds the counter at zero.
    function automatic logic [2:0] cnt_next(input logic [2:0] cnt, input logic inc, input logic dec);
        logic [2:0] res;
        case ({inc, dec})
            2'b10:   res = cnt + 3'd1;
            2'b01:   res = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
            default: res = cnt;
        endcase
        return res;
    endfunction

    // Arbitration, A-channel handshakes and winner payload with tagged source.
    always_comb begin
        elig0_s    = m0_a_valid && (cnt0_r < MAX_CNT);
        elig1_s    = m1_a_valid && (cnt1_r < MAX_CNT);
        loadable_s = reset_n && (!slice_valid_r || s_a_ready);
        if (elig0_s && elig1_s) begin
            win1_s = rr_ptr_r;
        end else if (elig1_s) begin
            win1_s = 1'b1;
        end else begin
            win1_s = 1'b0;
        end
        m0_a_ready = loadable_s && elig0_s && !win1_s;
        m1_a_ready = loadable_s && elig1_s && win1_s;
        a_hs0_s    = m0_a_valid && m0_a_ready;
        a_hs1_s    = m1_a_valid && m1_a_ready;
        if (win1_s) begin
            win_bits_s = {m1_a_bits[78:70], 1'b1, m1_a_bits[69:0]};
        end else begin
            win_bits_s = {m0_a_bits[78:70], 1'b0, m0_a_bits[69:0]};
        end
    end

    // D-channel routing on source[2], plus counter next-state.
    always_comb begin
        d_sel_s    = s_d_bits[37];
        m0_d_valid = s_d_valid && !d_sel_s;
        m1_d_valid = s_d_valid && d_sel_s;
        m0_d_bits  = {s_d_bits[45:38], s_d_bits[36:0]};
        m1_d_bits  = {s_d_bits[45:38], s_d_bits[36:0]};
        s_d_ready  = d_sel_s ? m1_d_ready : m0_d_ready;
        d_hs0_s    = m0_d_valid && m0_d_ready;
        d_hs1_s    = m1_d_valid && m1_d_ready;
        cnt0_nxt_s = cnt_next(cnt0_r, a_hs0_s, d_hs0_s);
        cnt1_nxt_s = cnt_next(cnt1_r, a_hs1_s, d_hs1_s);
    end

    // Output slice, round-robin pointer and outstanding counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slice_valid_r <= 1'b0;
            slice_bits_r  <= 80'd0;
            rr_ptr_r      <= 1'b0;
            cnt0_r        <= 3'd0;
            cnt1_r        <= 3'd0;
        end else begin
            if (a_hs0_s || a_hs1_s) begin
                slice_valid_r <= 1'b1;
                slice_bits_r  <= win_bits_s;
                rr_ptr_r      <= !win1_s;
            end else if (s_a_ready) begin
                slice_valid_r <= 1'b0;
            end else begin
                slice_valid_r <= slice_valid_r;
            end
            cnt0_r <= cnt0_nxt_s;
            cnt1_r <= cnt1_nxt_s;
        end
    end

    assign s_a_valid = slice_valid_r;
    assign s_a_bits  = slice_bits_r;
    assign idle      = !slice_valid_r && (cnt0_r == 3'd0) && (cnt1_r == 3'd0);

    tl_ul_arb2_chk #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_chk (
        .clock   (clock),
        .reset_n (reset_n),
        .d_hs0   (d_hs0_s),
        .d_hs1   (d_hs1_s),
        .cnt0    (cnt0_r),
        .cnt1    (cnt1_r)
    );

endmodule

// Protocol checker: unsolicited responses and counter overflow.
module tl_ul_arb2_chk #(
    parameter int MAX_OUTSTANDING = 4
) (
    input logic       clock,
    input logic       reset_n,
    input logic       d_hs0,
    input logic       d_hs1,
    input logic [2:0] cnt0,
    input logic [2:0] cnt1
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    a_unsolicited_0: assert property (@(posedge clock) disable iff (!reset_n) !(d_hs0 && cnt0 == 3'd0));
    a_unsolicited_1: assert property (@(posedge clock) disable iff (!reset_n) !(d_hs1 && cnt1 == 3'd0));
    a_limit:         assert property (@(posedge clock) disable iff (!reset_n) cnt0 <= MAX_CNT && cnt1 <= MAX_CNT);

endmodule
